// File: rtl/stream_demux.sv
// stream_demux: 1-to-NOUT stream distributor.
//   Each accepted input beat is written into the one-entry slot of the output
//   channel picked by in_sel. Slots drain independently, so a stalled consumer
//   only back-pressures beats addressed to its own channel. Beats whose in_sel
//   is >= NOUT are accepted, dropped, and flagged by a 1-cycle err pulse.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake; in_data payload, in_sel destination
//   out_valid/out_ready  per-channel handshake (bit k = channel k)
//   out_data             channel k payload at [k*WIDTH +: WIDTH]
//   err                  pulse: an out-of-range beat was dropped last cycle
//   beat_cnt             saturating count of beats loaded into slots

// One output slot: a register with valid bit. Load wins over drain, so a
// full slot can be refilled on the same edge it empties (no bubble).
module stream_demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             can_take
);
    assign can_take = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= din;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

module stream_demux #(
    parameter int WIDTH = 8,
    parameter int NOUT  = 2,
    parameter int SEL_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic                  err,
    output logic [15:0]           beat_cnt
);
    logic [NOUT-1:0]            hit;       // one-hot decode of in_sel
    logic [NOUT-1:0]            can_take;
    logic [NOUT-1:0]            load;
    logic [NOUT-1:0][WIDTH-1:0] data_arr;
    logic                       in_range;

    // Decoding by equality against each channel index keeps an out-of-range
    // in_sel from ever indexing past the slot array.
    always_comb begin
        hit      = '0;
        in_ready = 1'b1;
        for (int k = 0; k < NOUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                hit[k]   = 1'b1;
                in_ready = can_take[k];
            end
        end
    end

    assign in_range = |hit;
    assign load     = hit & {NOUT{in_valid & in_ready}};

    genvar g;
    generate
        for (g = 0; g < NOUT; g++) begin : g_slot
            stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load[g]),
                .din       (in_data),
                .out_ready (out_ready[g]),
                .out_valid (out_valid[g]),
                .out_data  (data_arr[g]),
                .can_take  (can_take[g])
            );
        end
    endgenerate

    assign out_data = data_arr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            // in_ready is forced high for out-of-range beats, so in_valid alone
            // means the beat was taken and dropped.
            err <= in_valid & ~in_range;
            if (|load && beat_cnt != 16'hFFFF)
                beat_cnt <= beat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_sel = '0;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready = '1;
    logic [N*W-1:0] out_data;
    logic          err;
    logic [15:0]   beat_cnt;

    int ntests = 0;
    int nfail  = 0;

    stream_demux #(.WIDTH(W), .NOUT(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Each channel holds at most one pending beat; m_last is what that channel
    // presents on its data bus (last beat ever loaded, 0 after reset).
    bit          m_full [N];
    logic [W-1:0] m_last [N];
    bit          m_err;
    int          m_cnt;

    function automatic bit model_ready();
        if (int'(in_sel) >= N) return 1'b1;
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_full[k] = 1'b0;
            m_last[k] = '0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n) model_clear();
        else begin
            bit acc;
            acc = in_valid && model_ready();
            for (int k = 0; k < N; k++)
                if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
            m_err = acc && int'(in_sel) >= N;
            if (acc && int'(in_sel) < N) begin
                m_full[in_sel] = 1'b1;
                m_last[in_sel] = in_data;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [N-1:0] ev;
            for (int k = 0; k < N; k++) begin
                ev[k] = m_full[k];
                chk($sformatf("data%0d", k), 32'(out_data[k*W +: W]), 32'(m_last[k]));
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("err", 32'(err), 32'(m_err));
            chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        do_reset();

        // 1: async reset mid-cycle clears a full slot with no clock edge
        out_ready = 3'b000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("t1_preload_valid", 32'(out_valid), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", 32'(out_valid), 32'h0);
        chk("t1_rst_data", 32'(out_data), 32'h0);
        chk("t1_rst_err", 32'(err), 32'h0);
        chk("t1_rst_cnt", 32'(beat_cnt), 32'h0);
        step();
        rst_n = 1'b1;
        out_ready = 3'b111;
        step();

        // 2: route A5 to ch1
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("t2_valid", 32'(out_valid), 32'h2);
        chk("t2_data", 32'(out_data[15:8]), 32'hA5);
        chk("t2_cnt", 32'(beat_cnt), 32'd1);
        step();
        chk("t2_drained", 32'(out_valid), 32'h0);
        chk("t2_hold", 32'(out_data[15:8]), 32'hA5);

        // 3: back-pressure on ch0
        out_ready = 3'b110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
        #1 chk("t3_rdy1", 32'(in_ready), 32'h1);
        step();
        in_data = 8'h22;
        #1 chk("t3_rdy2", 32'(in_ready), 32'h0);
        step();
        chk("t3_hold", 32'(out_data[7:0]), 32'h11);
        chk("t3_still_blocked", 32'(in_ready), 32'h0);
        out_ready = 3'b111;
        #1 chk("t3_unblock", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("t3_data", 32'(out_data[7:0]), 32'h22);
        chk("t3_valid", 32'(out_valid), 32'h1);
        step();

        // 4: ch0 stalled and full does not block ch1
        out_ready = 3'b110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h44;
        step();
        in_sel = 2'd1; in_data = 8'h33;
        #1 chk("t4_rdy", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("t4_ch1", 32'(out_data[15:8]), 32'h33);
        chk("t4_ch0", 32'(out_data[7:0]), 32'h44);
        chk("t4_valid", 32'(out_valid), 32'h3);
        out_ready = 3'b111;
        step();

        // 5: 10 back-to-back beats on ch0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'(i);
            #1 chk("t5_rdy", 32'(in_ready), 32'h1);
            step();
            chk("t5_data", 32'(out_data[7:0]), 32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("t5_cnt", 32'(beat_cnt), 32'd10);
        chk("t5_empty", 32'(out_valid), 32'h0);

        // 6: out-of-range sel drops the beat and pulses err
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
        #1 chk("t6_rdy", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("t6_err", 32'(err), 32'h1);
        chk("t6_novalid", 32'(out_valid), 32'h0);
        chk("t6_cnt", 32'(beat_cnt), 32'd10);
        step();
        chk("t6_err_gone", 32'(err), 32'h0);

        // top channel in range
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        chk("t6_ch2", 32'(out_data[23:16]), 32'hC3);
        chk("t6_ch2_valid", 32'(out_valid), 32'h4);
        chk("t6_cnt11", 32'(beat_cnt), 32'd11);

        // saturation: 11 + 65530 beats exceeds 16'hFFFF
        in_valid = 1'b1; in_sel = 2'd2;
        for (int i = 0; i < 65530; i++) begin
            in_data = 8'(i);
            step();
        end
        chk("t6_sat", 32'(beat_cnt), 32'hFFFF);
        in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        chk("t6_sat_hold", 32'(beat_cnt), 32'hFFFF);
        chk("t6_sat_data", 32'(out_data[23:16]), 32'hEE);
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
